// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encodings, instruction constants and
// small decode helpers used by the TAP register datapath.
package jtag_pkg;

  localparam logic [3:0] ST_TLR     = 4'd15;
  localparam logic [3:0] ST_RTI     = 4'd12;
  localparam logic [3:0] ST_SELDR   = 4'd7;
  localparam logic [3:0] ST_CAPDR   = 4'd6;
  localparam logic [3:0] ST_SHDR    = 4'd2;
  localparam logic [3:0] ST_EX1DR   = 4'd1;
  localparam logic [3:0] ST_PAUSEDR = 4'd3;
  localparam logic [3:0] ST_EX2DR   = 4'd0;
  localparam logic [3:0] ST_UPDDR   = 4'd5;
  localparam logic [3:0] ST_SELIR   = 4'd4;
  localparam logic [3:0] ST_CAPIR   = 4'd14;
  localparam logic [3:0] ST_SHIR    = 4'd10;
  localparam logic [3:0] ST_EX1IR   = 4'd9;
  localparam logic [3:0] ST_PAUSEIR = 4'd11;
  localparam logic [3:0] ST_EX2IR   = 4'd8;
  localparam logic [3:0] ST_UPDIR   = 4'd13;

  // BYPASS is all-ones at any IR width; truncate to the IR width in use.
  localparam logic [31:0] BYPASS_OP  = 32'hFFFF_FFFF;
  localparam logic [1:0]  IR_CAPTURE = 2'b01;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_e;

  function automatic logic is_shift_state(input logic [3:0] st);
    return (st == ST_SHDR) || (st == ST_SHIR);
  endfunction

endpackage

// File: rtl/jtag_tap_regs_if.sv
// Bundle between the TAP controller side and the TAP register datapath.
interface jtag_tap_regs_if #(
  parameter int IR_WIDTH   = 4,
  parameter int USER_WIDTH = 8
);
  logic [3:0]            state;
  logic                  tdi;
  logic                  tdo;
  logic                  tdo_en;
  logic [IR_WIDTH-1:0]   ir;
  logic [USER_WIDTH-1:0] user_capture;
  logic [USER_WIDTH-1:0] user_out;
  logic                  user_update;

  modport master (
    output state, tdi, user_capture,
    input  tdo, tdo_en, ir, user_out, user_update
  );

  modport slave (
    input  state, tdi, user_capture,
    output tdo, tdo_en, ir, user_out, user_update
  );
endinterface

// File: rtl/jtag_shift_reg.sv
// Generic JTAG capture/shift/update register; shifts right with tdi at the MSB.
// The optional update stage can be forced back to UPD_RST (used for TLR on the IR).
module jtag_shift_reg #(
  parameter int           W       = 8,
  parameter bit           HAS_UPD = 1'b1,
  parameter logic [W-1:0] UPD_RST = {W{1'b0}}
) (
  input  logic         CLK,
  input  logic         RESETN,
  input  logic         cap_en,
  input  logic         shift_en,
  input  logic         upd_en,
  input  logic         upd_rst,
  input  logic [W-1:0] cap_val,
  input  logic         tdi,
  output logic         so,
  output logic [W-1:0] po
);

  logic [W-1:0] sr_r;
  logic [W-1:0] shift_val_s;

  if (W > 1) begin : g_wide
    assign shift_val_s = {tdi, sr_r[W-1:1]};
  end else begin : g_one
    assign shift_val_s = tdi;
  end

  // Capture/shift register
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      sr_r <= {W{1'b0}};
    end else if (cap_en) begin
      sr_r <= cap_val;
    end else if (shift_en) begin
      sr_r <= shift_val_s;
    end else begin
      sr_r <= sr_r;
    end
  end

  assign so = sr_r[0];

  if (HAS_UPD) begin : g_upd
    logic [W-1:0] upd_r;

    // Parallel update register
    always_ff @(posedge CLK) begin
      if (!RESETN) begin
        upd_r <= UPD_RST;
      end else if (upd_rst) begin
        upd_r <= UPD_RST;
      end else if (upd_en) begin
        upd_r <= sr_r;
      end else begin
        upd_r <= upd_r;
      end
    end

    assign po = upd_r;
  end else begin : g_no_upd
    assign po = {W{1'b0}};
  end

endmodule

// File: rtl/jtag_tap_regs.sv
// JTAG IR/DR datapath: decodes TAP state and instruction into register
// enables, holds the BYPASS flop and muxes TDO.
module jtag_tap_regs
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH   = 4,
  parameter logic [31:0]         IDCODE     = 32'h1234_5679,
  parameter int                  USER_WIDTH = 8,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(4'h1),
  parameter logic [IR_WIDTH-1:0] OP_USER    = IR_WIDTH'(4'h8)
) (
  input logic            CLK,
  input logic            RESETN,
  jtag_tap_regs_if.slave bus
);

  localparam logic [IR_WIDTH-1:0] IR_CAP_VAL = IR_WIDTH'(IR_CAPTURE);
  localparam logic [IR_WIDTH-1:0] OP_BYPASS  = BYPASS_OP[IR_WIDTH-1:0];

  dr_sel_e             dr_sel_s;
  logic [IR_WIDTH-1:0] ir_s;
  logic                ir_so_s;
  logic                id_so_s;
  logic                user_so_s;
  logic [USER_WIDTH-1:0] user_po_s;
  logic                byp_r;
  logic                user_update_r;
  logic                tdo_s;

  logic tlr_s, cap_dr_s, sh_dr_s, upd_dr_s;
  logic id_cap_s, id_sh_s, user_cap_s, user_sh_s, user_upd_s, byp_cap_s, byp_sh_s;

  assign tlr_s    = (bus.state == ST_TLR);
  assign cap_dr_s = (bus.state == ST_CAPDR);
  assign sh_dr_s  = (bus.state == ST_SHDR);
  assign upd_dr_s = (bus.state == ST_UPDDR);

  // Instruction decode; unrecognised opcodes fall through to BYPASS
  always_comb begin
    dr_sel_s = DR_BYPASS;
    if (ir_s == OP_BYPASS) begin
      dr_sel_s = DR_BYPASS;
    end else if (ir_s == OP_IDCODE) begin
      dr_sel_s = DR_IDCODE;
    end else if (ir_s == OP_USER) begin
      dr_sel_s = DR_USER;
    end else begin
      dr_sel_s = DR_BYPASS;
    end
  end

  assign id_cap_s   = cap_dr_s && (dr_sel_s == DR_IDCODE);
  assign id_sh_s    = sh_dr_s  && (dr_sel_s == DR_IDCODE);
  assign user_cap_s = cap_dr_s && (dr_sel_s == DR_USER);
  assign user_sh_s  = sh_dr_s  && (dr_sel_s == DR_USER);
  assign user_upd_s = upd_dr_s && (dr_sel_s == DR_USER);
  assign byp_cap_s  = cap_dr_s && (dr_sel_s == DR_BYPASS);
  assign byp_sh_s   = sh_dr_s  && (dr_sel_s == DR_BYPASS);

  jtag_shift_reg #(.W(IR_WIDTH), .HAS_UPD(1'b1), .UPD_RST(OP_IDCODE)) u_ir (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .cap_en   (bus.state == ST_CAPIR),
    .shift_en (bus.state == ST_SHIR),
    .upd_en   (bus.state == ST_UPDIR),
    .upd_rst  (tlr_s),
    .cap_val  (IR_CAP_VAL),
    .tdi      (bus.tdi),
    .so       (ir_so_s),
    .po       (ir_s)
  );

  jtag_shift_reg #(.W(32), .HAS_UPD(1'b0)) u_idcode (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .cap_en   (id_cap_s),
    .shift_en (id_sh_s),
    .upd_en   (1'b0),
    .upd_rst  (1'b0),
    .cap_val  (IDCODE),
    .tdi      (bus.tdi),
    .so       (id_so_s),
    .po       ()
  );

  jtag_shift_reg #(.W(USER_WIDTH), .HAS_UPD(1'b1)) u_user (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .cap_en   (user_cap_s),
    .shift_en (user_sh_s),
    .upd_en   (user_upd_s),
    .upd_rst  (1'b0),
    .cap_val  (bus.user_capture),
    .tdi      (bus.tdi),
    .so       (user_so_s),
    .po       (user_po_s)
  );

  // BYPASS single-bit register
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      byp_r <= 1'b0;
    end else if (byp_cap_s) begin
      byp_r <= 1'b0;
    end else if (byp_sh_s) begin
      byp_r <= bus.tdi;
    end else begin
      byp_r <= byp_r;
    end
  end

  // USER update strobe, aligned with the new user_out value
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      user_update_r <= 1'b0;
    end else begin
      user_update_r <= user_upd_s;
    end
  end

  // TDO mux: LSB of whichever register is shifting, otherwise quiet
  always_comb begin
    tdo_s = 1'b0;
    case (bus.state)
      ST_SHIR: tdo_s = ir_so_s;
      ST_SHDR: begin
        case (dr_sel_s)
          DR_IDCODE: tdo_s = id_so_s;
          DR_USER:   tdo_s = user_so_s;
          DR_BYPASS: tdo_s = byp_r;
          default:   tdo_s = byp_r;
        endcase
      end
      default: tdo_s = 1'b0;
    endcase
  end

  assign bus.tdo         = tdo_s;
  assign bus.tdo_en      = is_shift_state(bus.state);
  assign bus.ir          = ir_s;
  assign bus.user_out    = user_po_s;
  assign bus.user_update = user_update_r;

endmodule

// File: tb/tb_jtag_tap_regs.sv
// Directed, table-driven bench for jtag_tap_regs: each record is one TCK cycle
// of controller state and tdi with the outputs expected during that cycle.
module tb_jtag_tap_regs;
  import jtag_pkg::*;

  logic CLK = 1'b0;
  logic RESETN;

  always #5 CLK = ~CLK;

  jtag_tap_regs_if #(.IR_WIDTH(4), .USER_WIDTH(8)) bus ();

  jtag_tap_regs #(
    .IR_WIDTH   (4),
    .IDCODE     (32'h1234_5679),
    .USER_WIDTH (8),
    .OP_IDCODE  (4'h1),
    .OP_USER    (4'h8)
  ) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  typedef struct {
    logic       rstn;
    logic [3:0] st;
    logic       tdi;
    logic [7:0] ucap;
    logic       chk;
    logic [3:0] eir;
    logic [7:0] euo;
    logic       eupd;
    logic       etdo;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  // Expected register view while the table is being written
  logic [3:0] m_ir;
  logic [7:0] m_uo;
  logic       m_chk;
  logic [7:0] m_ucap;
  logic       m_upd_next;

  task automatic add(input logic rstn, input logic [3:0] st, input logic tdi, input logic etdo);
    vec_t v;
    v.rstn = rstn;
    v.st   = st;
    v.tdi  = tdi;
    v.ucap = m_ucap;
    v.chk  = m_chk;
    v.eir  = m_ir;
    v.euo  = m_uo;
    v.eupd = m_upd_next;
    v.etdo = etdo;
    m_upd_next = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic shift_dr(input int n, input logic [31:0] tin, input logic [31:0] tout);
    for (int i = 0; i < n; i++) begin
      add(1'b1, ST_SHDR, tin[i], tout[i]);
    end
  endtask

  // 4-bit IR load; capture pattern 0001 always reads back as 1,0,0,0
  task automatic load_ir(input logic [3:0] op);
    add(1'b1, ST_CAPIR, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      add(1'b1, ST_SHIR, op[i], (i == 0) ? 1'b1 : 1'b0);
    end
    add(1'b1, ST_EX1IR, 1'b0, 1'b0);
    add(1'b1, ST_UPDIR, 1'b0, 1'b0);
    m_ir = op;
  endtask

  task automatic idcode_read();
    logic [31:0] idv;
    idv = 32'h1234_5679;
    add(1'b1, ST_TLR,   1'b0, 1'b0);
    m_ir = 4'h1;
    add(1'b1, ST_RTI,   1'b0, 1'b0);
    add(1'b1, ST_SELDR, 1'b0, 1'b0);
    add(1'b1, ST_CAPDR, 1'b0, 1'b0);
    shift_dr(32, 32'h0000_0000, idv);
    add(1'b1, ST_EX1DR, 1'b0, 1'b0);
    add(1'b1, ST_UPDDR, 1'b0, 1'b0);
    add(1'b1, ST_RTI,   1'b0, 1'b0);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    m_ir = 4'h0; m_uo = 8'h00; m_chk = 1'b0; m_ucap = 8'hA5; m_upd_next = 1'b0;

    // Reset, then IDCODE readout
    add(1'b0, ST_TLR, 1'b0, 1'b0);
    m_ir = 4'h1; m_uo = 8'h00; m_chk = 1'b1;
    idcode_read();

    // IR=F selects BYPASS: tdi 1,0,1,1 comes back as 0,1,0,1
    load_ir(4'hF);
    add(1'b1, ST_SELDR, 1'b0, 1'b0);
    add(1'b1, ST_CAPDR, 1'b0, 1'b0);
    shift_dr(4, 32'h0000_000D, 32'h0000_000A);
    add(1'b1, ST_EX1DR, 1'b0, 1'b0);
    add(1'b1, ST_UPDDR, 1'b0, 1'b0);
    add(1'b1, ST_RTI,   1'b0, 1'b0);

    // USER write: capture A5, shift in 3C, update
    load_ir(4'h8);
    m_ucap = 8'hA5;
    add(1'b1, ST_SELDR, 1'b0, 1'b0);
    add(1'b1, ST_CAPDR, 1'b0, 1'b0);
    shift_dr(8, 32'h0000_003C, 32'h0000_00A5);
    add(1'b1, ST_EX1DR, 1'b0, 1'b0);
    add(1'b1, ST_UPDDR, 1'b0, 1'b0);
    m_uo = 8'h3C; m_upd_next = 1'b1;
    add(1'b1, ST_RTI, 1'b0, 1'b0);
    add(1'b1, ST_RTI, 1'b0, 1'b0);

    // Unknown opcode 5 behaves as BYPASS; USER update suppressed
    load_ir(4'h5);
    add(1'b1, ST_SELDR, 1'b0, 1'b0);
    add(1'b1, ST_CAPDR, 1'b0, 1'b0);
    shift_dr(4, 32'h0000_0003, 32'h0000_0006);
    add(1'b1, ST_EX1DR, 1'b0, 1'b0);
    add(1'b1, ST_UPDDR, 1'b0, 1'b0);
    add(1'b1, ST_RTI,   1'b0, 1'b0);

    // Pause mid-shift: capture 5A, shift in C3 in two halves around PauseDR
    load_ir(4'h8);
    m_ucap = 8'h5A;
    add(1'b1, ST_SELDR, 1'b0, 1'b0);
    add(1'b1, ST_CAPDR, 1'b0, 1'b0);
    shift_dr(4, 32'h0000_0003, 32'h0000_000A);
    add(1'b1, ST_EX1DR, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      add(1'b1, ST_PAUSEDR, 1'b1, 1'b0);
    end
    add(1'b1, ST_EX2DR, 1'b0, 1'b0);
    shift_dr(4, 32'h0000_000C, 32'h0000_0005);
    add(1'b1, ST_EX1DR, 1'b0, 1'b0);
    add(1'b1, ST_UPDDR, 1'b0, 1'b0);
    m_uo = 8'hC3; m_upd_next = 1'b1;
    add(1'b1, ST_RTI, 1'b0, 1'b0);
    add(1'b1, ST_RTI, 1'b0, 1'b0);
    add(1'b1, ST_TLR, 1'b0, 1'b0);
    m_ir = 4'h1;
    add(1'b1, ST_RTI, 1'b0, 1'b0);

    // Reset during a USER shift
    load_ir(4'h8);
    add(1'b1, ST_SELDR, 1'b0, 1'b0);
    add(1'b1, ST_CAPDR, 1'b0, 1'b0);
    shift_dr(3, 32'h0000_0007, 32'h0000_0002);
    add(1'b0, ST_SHDR, 1'b1, 1'b1);
    m_ir = 4'h1; m_uo = 8'h00;
    add(1'b1, ST_SHDR, 1'b0, 1'b0);
    idcode_read();

    // Apply the table
    RESETN = 1'b1;
    bus.state = ST_TLR;
    bus.tdi = 1'b0;
    bus.user_capture = 8'h00;
    @(posedge CLK);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      RESETN           = vecs[i].rstn;
      bus.state        = vecs[i].st;
      bus.tdi          = vecs[i].tdi;
      bus.user_capture = vecs[i].ucap;
      @(negedge CLK);
      check("tdo", i, {31'd0, bus.tdo}, {31'd0, vecs[i].etdo});
      check("tdo_en", i, {31'd0, bus.tdo_en},
            {31'd0, ((vecs[i].st == ST_SHDR) || (vecs[i].st == ST_SHIR))});
      if (vecs[i].chk) begin
        check("ir", i, {28'd0, bus.ir}, {28'd0, vecs[i].eir});
        check("user_out", i, {24'd0, bus.user_out}, {24'd0, vecs[i].euo});
        check("user_update", i, {31'd0, bus.user_update}, {31'd0, vecs[i].eupd});
      end
      @(posedge CLK);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
